// File: rtl/pong_pkg.sv
// Pong game constants: state encoding, geometry defaults
// and derived centre/clamp positions shared with drawing logic.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } game_state_e;

  localparam int DEF_GRAPHICS_WIDTH   = 1280;
  localparam int DEF_GRAPHICS_HEIGHT  = 800;
  localparam int DEF_BORDER_WIDTH     = 50;
  localparam int DEF_PADDLE_X         = 110;
  localparam int DEF_PADDLE_WIDTH     = 20;
  localparam int DEF_PADDLE_LENGTH    = 200;
  localparam int DEF_PADDLE_SPEED     = 10;
  localparam int DEF_BALL_SIZE        = 16;
  localparam int DEF_BALL_SPEED       = 4;
  localparam int DEF_SERVE_FRAMES     = 60;
  localparam int DEF_START_LIVES      = 3;
  localparam int DEF_POSITION_REG_MAX = 11;

  localparam int BALL_X_CENTRE =
    DEF_GRAPHICS_WIDTH / 2 - DEF_BALL_SIZE / 2;
  localparam int BALL_Y_CENTRE =
    DEF_GRAPHICS_HEIGHT / 2 - DEF_BALL_SIZE / 2;
  localparam int PADDLE_Y_MIN = DEF_BORDER_WIDTH;
  localparam int PADDLE_Y_MAX =
    DEF_GRAPHICS_HEIGHT - DEF_BORDER_WIDTH - DEF_PADDLE_LENGTH;
  localparam int PADDLE_Y_RESET =
    (DEF_GRAPHICS_HEIGHT - DEF_PADDLE_LENGTH) / 2;

endpackage

// File: rtl/pong_controller_if.sv
// Control/status bundle between the game FSM and the
// ball motion unit.
interface pong_controller_if;
  logic        step;
  logic        center;
  logic [11:0] paddle_y;
  logic [11:0] ball_x;
  logic [11:0] ball_y;
  logic        hit;
  logic        miss;

  modport master (
    output step, center, paddle_y,
    input  ball_x, ball_y, hit, miss
  );

  modport slave (
    input  step, center, paddle_y,
    output ball_x, ball_y, hit, miss
  );
endinterface

// File: rtl/pong_ball.sv
// Ball motion with wall reflection, paddle hit and
// miss detection; all tests use pre-update values.
module pong_ball
  import pong_pkg::*;
#(
  parameter int GRAPHICS_WIDTH  = DEF_GRAPHICS_WIDTH,
  parameter int GRAPHICS_HEIGHT = DEF_GRAPHICS_HEIGHT,
  parameter int BORDER_WIDTH    = DEF_BORDER_WIDTH,
  parameter int PADDLE_X        = DEF_PADDLE_X,
  parameter int PADDLE_WIDTH    = DEF_PADDLE_WIDTH,
  parameter int PADDLE_LENGTH   = DEF_PADDLE_LENGTH,
  parameter int BALL_SIZE       = DEF_BALL_SIZE,
  parameter int BALL_SPEED      = DEF_BALL_SPEED
) (
  input logic i_clk,
  input logic i_reset,
  pong_controller_if.slave bus
);

  localparam logic [11:0] L_CX =
    12'(GRAPHICS_WIDTH / 2 - BALL_SIZE / 2);
  localparam logic [11:0] L_CY =
    12'(GRAPHICS_HEIGHT / 2 - BALL_SIZE / 2);
  localparam logic [11:0] L_SPD  = 12'(BALL_SPEED);
  localparam logic [11:0] L_SIZE = 12'(BALL_SIZE);
  localparam logic [11:0] L_PLEN = 12'(PADDLE_LENGTH);
  localparam logic [11:0] L_TOP  = 12'(BORDER_WIDTH);
  localparam logic [11:0] L_TOP_TH =
    12'(BORDER_WIDTH + BALL_SPEED);
  localparam logic [11:0] L_BOT_TH = 12'(GRAPHICS_HEIGHT
    - BORDER_WIDTH - BALL_SIZE - BALL_SPEED);
  localparam logic [11:0] L_BOT = L_BOT_TH + L_SPD;
  localparam logic [11:0] L_RGT_TH = 12'(GRAPHICS_WIDTH
    - BORDER_WIDTH - BALL_SIZE - BALL_SPEED);
  localparam logic [11:0] L_RGT = L_RGT_TH + L_SPD;
  localparam logic [11:0] L_HIT_LO =
    12'(PADDLE_X + PADDLE_WIDTH);
  localparam logic [11:0] L_HIT_HI = L_HIT_LO + L_SPD;
  localparam logic [11:0] L_MISS = L_TOP_TH;

  // dx: 1 = right, 0 = left; dy: 1 = down, 0 = up
  logic [11:0] r_x, r_y;
  logic        r_dx, r_dy;
  logic [11:0] w_x, w_y;
  logic        w_dx, w_dy, w_hit, w_miss;

  always_comb begin
    w_hit = ~r_dx
      && (r_x >= L_HIT_LO) && (r_x < L_HIT_HI)
      && ((r_y + L_SIZE) > bus.paddle_y)
      && (r_y < (bus.paddle_y + L_PLEN));
    w_miss = ~r_dx && ~w_hit && (r_x < L_MISS);
    w_x  = r_x;
    w_y  = r_y;
    w_dx = r_dx;
    w_dy = r_dy;
    if (r_dy) begin
      if (r_y > L_BOT_TH) begin
        w_y  = L_BOT;
        w_dy = 1'b0;
      end else begin
        w_y = r_y + L_SPD;
      end
    end else if (r_y < L_TOP_TH) begin
      w_y  = L_TOP;
      w_dy = 1'b1;
    end else begin
      w_y = r_y - L_SPD;
    end
    if (r_dx) begin
      if (r_x > L_RGT_TH) begin
        w_x  = L_RGT;
        w_dx = 1'b0;
      end else begin
        w_x = r_x + L_SPD;
      end
    end else if (w_hit) begin
      w_x  = L_HIT_LO;
      w_dx = 1'b1;
    end else if (!w_miss) begin
      w_x = r_x - L_SPD;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || bus.center) begin
      r_x  <= L_CX;
      r_y  <= L_CY;
      r_dx <= 1'b0;
      r_dy <= 1'b1;
    end else if (bus.step) begin
      r_x  <= w_x;
      r_y  <= w_y;
      r_dx <= w_dx;
      r_dy <= w_dy;
    end
  end

  assign bus.ball_x = r_x;
  assign bus.ball_y = r_y;
  assign bus.hit    = w_hit;
  assign bus.miss   = w_miss;

endmodule

// File: rtl/pong_controller.sv
// Pong game top: frame tick, game FSM, paddle and
// score/lives bookkeeping; ball motion lives in pong_ball.
module pong_controller
  import pong_pkg::*;
#(
  parameter int GRAPHICS_WIDTH   = DEF_GRAPHICS_WIDTH,
  parameter int GRAPHICS_HEIGHT  = DEF_GRAPHICS_HEIGHT,
  parameter int BORDER_WIDTH     = DEF_BORDER_WIDTH,
  parameter int PADDLE_X         = DEF_PADDLE_X,
  parameter int PADDLE_WIDTH     = DEF_PADDLE_WIDTH,
  parameter int PADDLE_LENGTH    = DEF_PADDLE_LENGTH,
  parameter int PADDLE_SPEED     = DEF_PADDLE_SPEED,
  parameter int BALL_SIZE        = DEF_BALL_SIZE,
  parameter int BALL_SPEED       = DEF_BALL_SPEED,
  parameter int SERVE_FRAMES     = DEF_SERVE_FRAMES,
  parameter int START_LIVES      = DEF_START_LIVES,
  parameter int POSITION_REG_MAX = DEF_POSITION_REG_MAX
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic        vga_vertical_sync,
  input  logic        button_north,
  input  logic        button_south,
  output logic [11:0] paddle_y,
  output logic [11:0] ball_x,
  output logic [11:0] ball_y,
  output logic        ball_visible,
  output logic [3:0]  score,
  output logic [1:0]  lives,
  output logic [1:0]  game_state
);

  localparam logic [11:0] L_P_MIN = 12'(BORDER_WIDTH);
  localparam logic [11:0] L_P_MAX = 12'(GRAPHICS_HEIGHT
    - BORDER_WIDTH - PADDLE_LENGTH);
  localparam logic [11:0] L_P_RST =
    12'((GRAPHICS_HEIGHT - PADDLE_LENGTH) / 2);
  localparam logic [11:0] L_P_SPD = 12'(PADDLE_SPEED);
  localparam logic [11:0] L_SERVE = 12'(SERVE_FRAMES);
  localparam logic [1:0]  L_LIVES = 2'(START_LIVES);

  game_state_e r_state, w_state;
  logic        r_vs_d;
  logic [11:0] r_paddle, w_paddle;
  logic [11:0] r_cnt, w_cnt;
  logic [3:0]  r_score, w_score;
  logic [1:0]  r_lives, w_lives;
  logic        r_visible;
  logic        w_tick, w_any, w_live;

  pong_controller_if u_bus ();

  pong_ball #(
    .GRAPHICS_WIDTH  (GRAPHICS_WIDTH),
    .GRAPHICS_HEIGHT (GRAPHICS_HEIGHT),
    .BORDER_WIDTH    (BORDER_WIDTH),
    .PADDLE_X        (PADDLE_X),
    .PADDLE_WIDTH    (PADDLE_WIDTH),
    .PADDLE_LENGTH   (PADDLE_LENGTH),
    .BALL_SIZE       (BALL_SIZE),
    .BALL_SPEED      (BALL_SPEED)
  ) u_ball (
    .i_clk   (pixel_clock),
    .i_reset (reset),
    .bus     (u_bus.slave)
  );

  assign w_tick = vga_vertical_sync & ~r_vs_d;
  assign w_any  = button_north | button_south;
  assign w_live = (r_state == ST_SERVE)
               || (r_state == ST_PLAY);

  // Ball recentres on every tick outside play and on a miss
  assign u_bus.step     = w_tick && (r_state == ST_PLAY);
  assign u_bus.center   = w_tick
    && ((r_state != ST_PLAY) || u_bus.miss);
  assign u_bus.paddle_y = r_paddle;

  always_comb begin
    w_state  = r_state;
    w_paddle = r_paddle;
    w_cnt    = r_cnt;
    w_score  = r_score;
    w_lives  = r_lives;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state = ST_SERVE;
          w_score = 4'd0;
          w_lives = L_LIVES;
          w_cnt   = L_SERVE;
        end
      end
      ST_SERVE: begin
        if (r_cnt != 12'd0)
          w_cnt = r_cnt - 12'd1;
        if (r_cnt <= 12'd1)
          w_state = ST_PLAY;
      end
      ST_PLAY: begin
        if (u_bus.hit && (r_score != 4'd15))
          w_score = r_score + 4'd1;
        if (u_bus.miss) begin
          if (r_lives != 2'd0)
            w_lives = r_lives - 2'd1;
          if (r_lives <= 2'd1) begin
            w_state = ST_OVER;
          end else begin
            w_state = ST_SERVE;
            w_cnt   = L_SERVE;
          end
        end
      end
      ST_OVER: begin
        if (!w_any)
          w_state = ST_IDLE;
      end
      default: w_state = ST_IDLE;
    endcase
    if (w_live) begin
      unique case (1'b1)
        button_north && !button_south:
          w_paddle = (r_paddle < L_P_MIN + L_P_SPD)
            ? L_P_MIN : r_paddle - L_P_SPD;
        button_south && !button_north:
          w_paddle = (r_paddle > L_P_MAX - L_P_SPD)
            ? L_P_MAX : r_paddle + L_P_SPD;
        default: w_paddle = r_paddle;
      endcase
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      r_vs_d    <= 1'b1;
      r_state   <= ST_IDLE;
      r_paddle  <= L_P_RST;
      r_cnt     <= 12'd0;
      r_score   <= 4'd0;
      r_lives   <= L_LIVES;
      r_visible <= 1'b0;
    end else begin
      r_vs_d <= vga_vertical_sync;
      if (w_tick) begin
        r_state   <= w_state;
        r_paddle  <= w_paddle;
        r_cnt     <= w_cnt;
        r_score   <= w_score;
        r_lives   <= w_lives;
        r_visible <= (w_state == ST_SERVE)
                  || (w_state == ST_PLAY);
      end
    end
  end

  assign paddle_y     = r_paddle;
  assign ball_x       = u_bus.ball_x;
  assign ball_y       = u_bus.ball_y;
  assign ball_visible = r_visible;
  assign score        = r_score;
  assign lives        = r_lives;
  assign game_state   = r_state;

endmodule
